// File: rtl/frequency_sweep.sv
// frequency_sweep: stepped chirp controller producing the phase-increment word for the NCO.
module frequency_sweep #(
    parameter int WIDTH       = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   ipClk,
    input  logic                   ipnReset,
    input  logic                   ipStart,
    input  logic                   ipAbort,
    input  logic [WIDTH-1:0]       ipStartFreq,
    input  logic [WIDTH-1:0]       ipStopFreq,
    input  logic [WIDTH-1:0]       ipStep,
    input  logic [DWELL_WIDTH-1:0] ipDwell,
    input  logic [1:0]             ipMode,
    output logic [WIDTH-1:0]       opFrequency,
    output logic                   opBusy,
    output logic                   opDone,
    output logic                   opWrap
);
    typedef enum logic {Idle, Dwell} stateT;

    stateT                  state;
    logic [WIDTH-1:0]       startFreq;
    logic [WIDTH-1:0]       stopFreq;
    logic [WIDTH-1:0]       stepSize;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [DWELL_WIDTH-1:0] dwellCount;
    logic [1:0]             mode;
    logic                   dirUp;
    logic                   toStop;

    function automatic logic [WIDTH-1:0] stepToward(input logic [WIDTH-1:0] cur, tgt, step, input logic up);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] diff;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (up)
            return (sum >= {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
        return (diff[WIDTH] || diff[WIDTH-1:0] <= tgt) ? tgt : diff[WIDTH-1:0];
    endfunction

    logic             startUp;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] turnTarget;
    logic             movingUp;
    logic [WIDTH-1:0] nextStep;
    logic [WIDTH-1:0] turnStep;

    // toStop tracks which endpoint is the current leg's goal; movingUp is the resulting direction
    always_comb begin
        startUp    = ipStopFreq >= ipStartFreq;
        span       = startUp ? ipStopFreq - ipStartFreq : ipStartFreq - ipStopFreq;
        target     = toStop ? stopFreq : startFreq;
        turnTarget = toStop ? startFreq : stopFreq;
        movingUp   = toStop ? dirUp : !dirUp;
        nextStep   = stepToward(opFrequency, target, stepSize, movingUp);
        turnStep   = stepToward(opFrequency, turnTarget, stepSize, !movingUp);
    end

    always_ff @(posedge ipClk or negedge ipnReset) begin
        if (!ipnReset) begin
            state       <= Idle;
            startFreq   <= '0;
            stopFreq    <= '0;
            stepSize    <= '0;
            dwell       <= '0;
            dwellCount  <= '0;
            mode        <= '0;
            dirUp       <= 1'b1;
            toStop      <= 1'b1;
            opFrequency <= '0;
            opBusy      <= 1'b0;
            opDone      <= 1'b0;
            opWrap      <= 1'b0;
        end else begin
            opDone <= 1'b0;
            opWrap <= 1'b0;
            if (ipAbort) begin
                state  <= Idle;
                opBusy <= 1'b0;
            end else if (state == Idle) begin
                if (ipStart) begin
                    startFreq   <= ipStartFreq;
                    stopFreq    <= ipStopFreq;
                    stepSize    <= (ipStep == '0) ? span : ipStep;
                    dwell       <= ipDwell;
                    mode        <= ipMode;
                    dirUp       <= startUp;
                    toStop      <= 1'b1;
                    dwellCount  <= '0;
                    opFrequency <= ipStartFreq;
                    opBusy      <= 1'b1;
                    state       <= Dwell;
                end
            end else if (dwellCount != dwell) begin
                dwellCount <= dwellCount + 1'b1;
            end else begin
                dwellCount <= '0;
                if (opFrequency != target) begin
                    opFrequency <= nextStep;
                end else if (mode == 2'd1) begin
                    opFrequency <= startFreq;
                    opWrap      <= 1'b1;
                end else if (mode == 2'd2) begin
                    opFrequency <= turnStep;
                    toStop      <= !toStop;
                    opWrap      <= 1'b1;
                end else begin
                    opDone <= 1'b1;
                    opBusy <= 1'b0;
                    state  <= Idle;
                end
            end
        end
    end
endmodule
